// File: rtl/iterative_shift_sequencer.sv
// iterative_shift_sequencer
// Multi-cycle 32-bit shifter for the ALU shift path. One reused coarse stage
// (4 bits) and one fine stage (1 bit) replace a full barrel shifter. Each
// clock in SHIFT applies one step until the latched amount is consumed.
//
// Handshake: start is sampled only in IDLE or DONE and is accepted on that
// rising edge. busy is high in every SHIFT cycle, and start is ignored while
// busy. done is a one-cycle pulse and is never high together with busy.
// result is valid while done is high and holds until the next done. Issuing
// start in a DONE cycle begins the next operation back-to-back.
module iterative_shift_sequencer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] data_in,
  input  logic [4:0]  shamt,
  input  logic [1:0]  op,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  logic [1:0]  state;
  logic [31:0] work;
  logic [4:0]  remaining;
  logic [1:0]  op_q;

  logic        accept;
  logic        coarse;
  logic [31:0] shifted;
  logic [4:0]  rem_next;

  // Start is only honoured when no shift is in flight.
  assign accept = start && ((state == S_IDLE) || (state == S_DONE));

  // Coarse step while at least 4 bits remain, otherwise a 1-bit fine step.
  assign coarse   = (remaining >= 5'd4);
  assign rem_next = coarse ? (remaining - 5'd4) : (remaining - 5'd1);

  // One shift step of the working value; SRA fills from work[31], which
  // still carries the original sign after earlier steps.
  always_comb begin
    shifted = work;
    case (op_q)
      OP_SLL: shifted = coarse ? {work[27:0], 4'b0000} : {work[30:0], 1'b0};
      OP_SRL: shifted = coarse ? {4'b0000, work[31:4]} : {1'b0, work[31:1]};
      OP_SRA: shifted = coarse ? {{4{work[31]}}, work[31:4]} : {work[31], work[31:1]};
      default: shifted = work;
    endcase
  end

  // Control FSM plus operand, counter and result registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      work      <= 32'd0;
      remaining <= 5'd0;
      op_q      <= OP_SLL;
      result    <= 32'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            work      <= data_in;
            remaining <= shamt;
            op_q      <= op;
            if ((shamt != 5'd0) && (op != OP_RSV)) begin
              state <= S_SHIFT;
            end else begin
              // Nothing to shift: the operand is the answer.
              state  <= S_DONE;
              result <= data_in;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          work      <= shifted;
          remaining <= rem_next;
          if (rem_next == 5'd0) begin
            state  <= S_DONE;
            result <= shifted;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status outputs are plain decodes of the registered state.
  assign busy      = (state == S_SHIFT);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_iterative_shift_sequencer.sv
// Testbench for iterative_shift_sequencer: directed cases from the design
// notes followed by randomized operations, scored against a reference model
// that computes the shifted value and the step count arithmetically.
module tb_iterative_shift_sequencer;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic [1:0]  op;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  int          exp_n_q[$];
  logic [31:0] last_result;

  iterative_shift_sequencer dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .data_in   (data_in),
    .shamt     (shamt),
    .op        (op),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model
  function automatic logic [31:0] ref_result(input logic [31:0] d, input int s, input logic [1:0] o);
    logic signed [31:0] sd;
    sd = d;
    case (o)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return sd >>> s;
      default: return d;
    endcase
  endfunction

  function automatic int ref_steps(input int s, input logic [1:0] o);
    if (o == 2'b11 || s == 0) return 0;
    return s / 4 + s % 4;
  endfunction

  // Driver: called at a falling edge; returns at the falling edge after the
  // accepting rising edge, with start deasserted.
  task automatic start_op(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o);
    start   = 1'b1;
    data_in = d;
    shamt   = s;
    op      = o;
    exp_q.push_back(ref_result(d, int'(s), o));
    exp_n_q.push_back(ref_steps(int'(s), o));
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
  endtask

  // Monitor one operation until done; returns at the falling edge of the
  // done cycle. pre_busy counts busy cycles already seen by the caller.
  task automatic wait_done(input string tag, input int pre_busy);
    logic [31:0] exp_r;
    int          exp_n;
    int          busy_cnt;
    bit          seen;
    bit          overlap;
    bit          held_ok;
    exp_r    = exp_q.pop_front();
    exp_n    = exp_n_q.pop_front();
    busy_cnt = pre_busy;
    seen     = 1'b0;
    overlap  = 1'b0;
    held_ok  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (busy && done) overlap = 1'b1;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) begin
        busy_cnt++;
        if (result !== last_result) held_ok = 1'b0;
      end
      @(negedge clock);
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_n));
    check({tag, "_result"}, result, exp_r);
    check({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
    check({tag, "_result_held"}, 32'(held_ok), 32'd1);
    last_result = exp_r;
  endtask

  // Done must drop after its single cycle when no new start arrives.
  task automatic check_done_pulse(input string tag);
    @(negedge clock);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_result_hold"}, result, last_result);
  endtask

  initial begin
    logic [31:0] rd;
    logic [4:0]  rs;
    logic [1:0]  ro;
    bit          b2b;
    start       = 1'b0;
    data_in     = 32'd0;
    shamt       = 5'd0;
    op          = 2'b00;
    last_result = 32'd0;
    reset_n     = 1'b0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // SLL 1 by 5: two steps
    start_op(32'h0000_0001, 5'd5, 2'b00);
    wait_done("sll5", 0);
    check_done_pulse("sll5");

    // SRA / SRL by 31: ten steps
    start_op(32'h8000_0000, 5'd31, 2'b10);
    wait_done("sra31", 0);
    check_done_pulse("sra31");
    start_op(32'h8000_0000, 5'd31, 2'b01);
    wait_done("srl31", 0);
    check_done_pulse("srl31");

    // Zero shift and reserved op go straight to DONE
    start_op(32'hF000_000F, 5'd0, 2'b01);
    wait_done("zero", 0);
    check_done_pulse("zero");
    start_op(32'hF000_000F, 5'd9, 2'b11);
    wait_done("rsv", 0);
    check_done_pulse("rsv");

    // Start during SHIFT is ignored
    start_op(32'h1234_5678, 5'd8, 2'b01);
    check("ign_busy_first", 32'(busy), 32'd1);
    start   = 1'b1;
    data_in = 32'hFFFF_FFFF;
    shamt   = 5'd1;
    op      = 2'b00;
    @(negedge clock);
    start = 1'b0;
    wait_done("ign", 1);
    check_done_pulse("ign");

    // Back-to-back: new start issued in the DONE cycle
    start_op(32'h0000_00FF, 5'd4, 2'b00);
    wait_done("b2b_a", 0);
    start_op(32'h0000_0F0F, 5'd6, 2'b01);
    wait_done("b2b_b", 0);
    check_done_pulse("b2b_b");

    // Asynchronous reset in the middle of SHIFT
    start_op(32'h8000_0000, 5'd31, 2'b10);
    exp_q.delete();
    exp_n_q.delete();
    for (int i = 0; i < 3; i++) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_result", result, 32'd0);
    last_result = 32'd0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_no_done", 32'(done), 32'd0);
    start_op(32'h0000_0001, 5'd2, 2'b00);
    wait_done("post_rst", 0);
    check_done_pulse("post_rst");

    // Randomized operations, sometimes chained back-to-back
    b2b = 1'b0;
    for (int n = 0; n < 60; n++) begin
      rd = $urandom;
      rs = 5'($urandom_range(0, 31));
      ro = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) rd[31] = 1'b1;
      start_op(rd, rs, ro);
      wait_done("rand", 0);
      b2b = ($urandom_range(0, 1) == 1);
      if (!b2b) check_done_pulse("rand");
    end
    if (b2b) check_done_pulse("rand_tail");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iterative_shift_sequencer.md
# iterative_shift_sequencer

Multi-cycle shift controller for the ALU shift path. It latches a 32-bit operand, a 5-bit shift amount and a shift type, then repeatedly applies one fixed coarse step (4 bits) or fine step (1 bit) per clock until the requested amount has been consumed. It replaces a full 5-level barrel shifter with one reused coarse stage and one fine stage. It presents a start/busy/done handshake to the ALU control.

## Interface
- Parameters: none. Data width is fixed at 32, coarse step at 4 and fine step at 1.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request pulse. Sampled only in IDLE or DONE.
- `data_in` in 32: operand, latched when start is accepted.
- `shamt` in 5: shift amount 0–31, latched when start is accepted.
- `op` in 2: shift type, latched when start is accepted. 00 = SLL, 01 = SRL, 10 = SRA, 11 = reserved (pass-through).
- `busy` out 1: high while in SHIFT.
- `done` out 1: one-cycle pulse; `result` is valid in that cycle.
- `result` out 32: final shifted value, held until the next `done`.

## Operation
- Internal state:
  - `work` register (32 bits)
  - `remaining` counter (5 bits)
  - latched `op_q`
  - FSM with states IDLE, SHIFT, DONE
- Start acceptance:
  - `start` is accepted when state is IDLE or DONE.
  - On acceptance: `work` ← `data_in`, `remaining` ← `shamt`, `op_q` ← `op`.
  - Next state is SHIFT if `shamt` ≠ 0 and `op` ≠ 11; otherwise next state is DONE.
- SHIFT step (one per clock):
  - If `remaining` ≥ 4: shift `work` by 4 and set `remaining` −= 4.
  - Else: shift `work` by 1 and set `remaining` −= 1.
- Fill rules:
  - SLL shifts left with zero fill.
  - SRL shifts right with zero fill.
  - SRA shifts right, filling with `work[31]`. This equals the original sign bit because the sign propagates.
- Step count: N = floor(shamt/4) + (shamt mod 4). Maximum N = 10, at shamt = 31.
- Leaving SHIFT: when the step drives `remaining` to 0, next state is DONE and `result` ← shifted `work` on that same edge.
- Zero-shift and reserved cases: `result` ← `data_in` on the accepting edge (state goes straight to DONE).
- DONE:
  - Lasts exactly one cycle with `done` = 1.
  - Next state is IDLE, unless `start` is accepted, in which case the new operation begins (back-to-back).
- `start` in SHIFT is ignored. Nothing is queued and the latched operands are unaffected.
- Reserved `op` = 11 never enters SHIFT, regardless of `shamt`.

## Timing
- Reset values (asynchronous, immediately on `reset_n` low):
  - state = IDLE
  - `busy` = 0, `done` = 0
  - `result` = 0x0000_0000
  - `work` = 0, `remaining` = 0
- Reset mid-SHIFT aborts the operation. No `done` is produced, and the first start after `reset_n` rises is accepted normally.
- Outputs `busy` and `done` are registered state decodes. There is no combinational path from inputs to outputs.
- Latency: `done` is high in the cycle after the (N+1)th rising edge, counting the edge that samples `start` as edge 1. Shamt 0 → 1 cycle; shamt 31 → 11 cycles.
- `busy` is high for exactly N cycles per operation and is never high together with `done`.
- Throughput: one operation per N+1 cycles when `start` is asserted in every DONE cycle.

## Test plan
- SLL, `data_in` 0x0000_0001, `shamt` 5, start at edge E1 → N = 2, `busy` high 2 cycles, `done` after E3, `result` 0x0000_0020.
- SRA, `data_in` 0x8000_0000, `shamt` 31 → 10 busy cycles, `done` after the 11th edge, `result` 0xFFFF_FFFF. Repeat with SRL → `result` 0x0000_0001.
- SRL, `data_in` 0xF000_000F, `shamt` 0 → `busy` never high, `done` the next cycle, `result` 0xF000_000F. Same response for `op` 11 with `shamt` 9.
- SRL, `data_in` 0x1234_5678, `shamt` 8; a second start one cycle later with 0xFFFF_FFFF, `shamt` 1 → second start ignored, `done` once, `result` 0x0012_3456.
- Back-to-back: assert `start` during the DONE cycle of the previous operation (SLL 0x0000_00FF, `shamt` 4) → the previous `result` is held during that DONE cycle, then `busy` rises next cycle; `result` 0x0000_0FF0 after 2 more edges.
- Pull `reset_n` low mid-SHIFT (SRA 0x8000_0000, `shamt` 31, after 3 steps) → `busy`, `done` and `result` go to 0 immediately. A new SLL 0x1, `shamt` 2 then completes in 3 edges with `result` 0x0000_0004.
